// File: rtl/breakout_pkg.sv
// Shared constants for the breakout input stage: button indices, channel count,
// default debounce interval and the per-channel debounce action type.
package breakout_pkg;

   localparam int N_BTN      = 3;
   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_SELECT = 2;

   // 10 ms at a 25 MHz pixel clock.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

   typedef enum logic [1:0] {
      DB_IDLE,    // synchronised input agrees with the accepted level
      DB_HOLD,    // disagreement seen but counting is paused
      DB_COUNT,   // disagreement seen, still qualifying
      DB_ACCEPT   // disagreement held long enough, take the new level
   } db_action_e;

   function automatic int debounce_cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, enable-gated debounce counter,
// accepted level and registered one-cycle press/release pulses.
module debounce_channel
   import breakout_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   localparam int CNT_W           = debounce_cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic nRst,
   input  logic en,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             level_q,   level_d;
   logic             press_q,   press_d;
   logic             release_q, release_d;
   db_action_e       action;

   always_comb begin
      action = DB_IDLE;
      if (sync2_q != level_q) begin
         if (!en) begin
            action = DB_HOLD;
         end else if (cnt_q == CNT_LAST) begin
            action = DB_ACCEPT;
         end else begin
            action = DB_COUNT;
         end
      end
   end

   // NOTE: every next-state signal gets a default first so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (action)
         DB_IDLE:   cnt_d = '0;
         DB_HOLD:   cnt_d = cnt_q;
         DB_COUNT:  cnt_d = cnt_q + CNT_W'(1);
         DB_ACCEPT: begin
            cnt_d     = '0;
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
         end
         default:   cnt_d = '0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so the synchroniser
   // stages shift by exactly one flop per edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Input stage for the breakout top: synchronises and debounces the raw
// pushbuttons, giving clean levels plus one-cycle press and release pulses.
module button_conditioner #(
   parameter int N_BTN           = breakout_pkg::N_BTN,
   parameter int DEBOUNCE_CYCLES = breakout_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             en,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   // Channels share only clock, reset and enable; timing is fully per bit.
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk         (clk),
         .nRst        (nRst),
         .en          (en),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus a randomised run
// compared each cycle against a behavioural model of the debounce rules.
module tb_button_conditioner;
   import breakout_pkg::*;

   localparam int D = 4;

   logic             clk = 1'b0;
   logic             nRst;
   logic             en;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level, btn_press, btn_release;
   logic [N_BTN-1:0] l1, p1, r1;

   int errors = 0;
   int checks = 0;

   // Reference model state: raw samples delayed two edges, accepted level,
   // pulses, and how many enabled edges the current disagreement has lasted.
   logic [N_BTN-1:0] m_s1, m_s2, m_level, m_press, m_rel;
   int               run [N_BTN];

   always #5 clk = ~clk;

   button_conditioner #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .nRst(nRst), .en(en), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
   );

   button_conditioner #(.N_BTN(N_BTN), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .nRst(nRst), .en(en), .btn_raw(btn_raw),
      .btn_level(l1), .btn_press(p1), .btn_release(r1)
   );

   function automatic void model_edge();
      if (!nRst) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
         for (int i = 0; i < N_BTN; i++) run[i] = 0;
         return;
      end
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if (m_s2[i] == m_level[i]) begin
            run[i] = 0;
         end else if (en) begin
            run[i]++;
            if (run[i] == D) begin
               m_level[i] = m_s2[i];
               m_press[i] = m_s2[i];
               m_rel[i]   = ~m_s2[i];
               run[i]     = 0;
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      nRst = 1'b0; en = 1'b1; btn_raw = '0;
      repeat (3) tick();
      checks++;
      if ({btn_level, btn_press, btn_release, l1, p1, r1} !== '0) begin
         errors++;
         $display("FAIL reset_hold level=%b press=%b release=%b d1=%b%b%b expected all 0",
                  btn_level, btn_press, btn_release, l1, p1, r1);
      end
      nRst = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         checks++;
         if ({btn_level, btn_press, btn_release, l1, p1, r1} !== '0) begin
            errors++;
            $display("FAIL reset_release cycle=%0d level=%b press=%b release=%b expected all 0",
                     c, btn_level, btn_press, btn_release);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [N_BTN-1:0] exp_l, exp_p, exp_l1, exp_p1;
      btn_raw = 3'b001;
      tick();  // edge 0 samples the rise
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp_l  = (e >= 5) ? 3'b001 : 3'b000;
         exp_p  = (e == 5) ? 3'b001 : 3'b000;
         exp_l1 = (e >= 2) ? 3'b001 : 3'b000;
         exp_p1 = (e == 2) ? 3'b001 : 3'b000;
         checks++;
         if (btn_level !== exp_l || btn_press !== exp_p || btn_release !== 3'b000) begin
            errors++;
            $display("FAIL clean_press edge=%0d level=%b press=%b release=%b expected %b %b 000",
                     e, btn_level, btn_press, btn_release, exp_l, exp_p);
         end
         checks++;
         if (l1 !== exp_l1 || p1 !== exp_p1 || r1 !== 3'b000) begin
            errors++;
            $display("FAIL press_d1 edge=%0d level=%b press=%b release=%b expected %b %b 000",
                     e, l1, p1, r1, exp_l1, exp_p1);
         end
      end
   endtask

   task automatic test_bounce();
      for (int p = 0; p < 4; p++) begin
         btn_raw[1] = (p % 2 == 0);
         repeat (3) begin
            tick();
            checks++;
            if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_release[1] !== 1'b0) begin
               errors++;
               $display("FAIL bounce_reject level=%b press=%b release=%b expected bit1 all 0",
                        btn_level, btn_press, btn_release);
            end
         end
      end
      btn_raw[1] = 1'b1;
      tick();  // final rise sampled here
      for (int e = 1; e <= 7; e++) begin
         tick();
         checks++;
         if (btn_level[1] !== (e >= 5) || btn_press[1] !== (e == 5) || btn_release[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_settle edge=%0d level=%b press=%b release=%b expected bit1 level=%0d press=%0d",
                     e, btn_level, btn_press, btn_release, (e >= 5), (e == 5));
         end
      end
   endtask

   task automatic test_enable();
      btn_raw[2] = 1'b1;
      en = 1'b1;
      repeat (2) tick();  // sample and synchronise
      repeat (2) tick();  // two enabled qualifying edges
      en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (btn_level[2] !== 1'b0 || btn_press[2] !== 1'b0) begin
            errors++;
            $display("FAIL enable_gated cycle=%0d level=%b press=%b expected bit2 0",
                     c, btn_level, btn_press);
         end
      end
      en = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         checks++;
         if (btn_level[2] !== (e >= 2) || btn_press[2] !== (e == 2)) begin
            errors++;
            $display("FAIL enable_resume edge=%0d level=%b press=%b expected bit2 level=%0d press=%0d",
                     e, btn_level, btn_press, (e >= 2), (e == 2));
         end
      end
   endtask

   task automatic test_release_simul();
      logic [N_BTN-1:0] exp_l, exp_r;
      btn_raw = 3'b010;
      tick();
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp_l = (e >= 5) ? 3'b010 : 3'b111;
         exp_r = (e == 5) ? 3'b101 : 3'b000;
         checks++;
         if (btn_level !== exp_l || btn_release !== exp_r || btn_press !== 3'b000) begin
            errors++;
            $display("FAIL release_simul edge=%0d level=%b press=%b release=%b expected %b 000 %b",
                     e, btn_level, btn_press, btn_release, exp_l, exp_r);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [N_BTN-1:0] exp_l, exp_p;
      btn_raw = 3'b011;
      repeat (5) tick();  // sample, synchronise, then three counted edges
      checks++;
      if (btn_level !== 3'b010) begin
         errors++;
         $display("FAIL midcount_level level=%b expected 010", btn_level);
      end
      nRst = 1'b0;
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
         errors++;
         $display("FAIL midcount_reset level=%b press=%b release=%b expected all 0",
                  btn_level, btn_press, btn_release);
      end
      nRst = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp_l = (e >= D + 2) ? 3'b011 : 3'b000;
         exp_p = (e == D + 2) ? 3'b011 : 3'b000;
         checks++;
         if (btn_level !== exp_l || btn_press !== exp_p || btn_release !== 3'b000) begin
            errors++;
            $display("FAIL midcount_restart edge=%0d level=%b press=%b release=%b expected %b %b 000",
                     e, btn_level, btn_press, btn_release, exp_l, exp_p);
         end
      end
   endtask

   task automatic test_random();
      int hold [N_BTN];
      for (int i = 0; i < N_BTN; i++) hold[i] = $urandom_range(1, 9);
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N_BTN; i++) begin
            if (hold[i] == 0) begin
               btn_raw[i] = ~btn_raw[i];
               hold[i]    = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 20) : $urandom_range(1, 6);
            end else begin
               hold[i]--;
            end
         end
         en   = ($urandom_range(0, 7) != 0);
         nRst = ($urandom_range(0, 399) != 0);
         tick();
         checks++;
         if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
            errors++;
            $display("FAIL random_model cycle=%0d level=%b press=%b release=%b expected %b %b %b",
                     c, btn_level, btn_press, btn_release, m_level, m_press, m_rel);
         end
         checks++;
         if ((btn_press & btn_release) !== '0) begin
            errors++;
            $display("FAIL pulse_exclusive cycle=%0d press=%b release=%b expected no overlap",
                     c, btn_press, btn_release);
         end
      end
      nRst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      nRst = 1'b0; en = 1'b1; btn_raw = '0;
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N_BTN; i++) run[i] = 0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_enable();
      test_release_simul();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the breakout top level.
- Takes raw asynchronous pushbutton pins (left, right, select) and produces clean, debounced button levels plus one-cycle press and release pulses.
- The top-level `btn_left`, `btn_right` and `btn_select` inputs are driven from `btn_level`.
- Press pulses are reserved for game-state logic such as serve and restart on select.

Parameters:
- N_BTN, 3: number of button channels. Bit 0 = left, 1 = right, 2 = select.
- DEBOUNCE_CYCLES, 250000: enabled clock cycles an input must hold a new value before it is accepted. 10 ms at 25 MHz. Must be ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: width of each per-channel counter. Derived; not overridden.

Ports:
- clk  in  1  pixel clock, rising edge
- nRst  in  1  synchronous active-low reset
- en  in  1  count enable; debounce counters advance only when high
- btn_raw  in  N_BTN  raw asynchronous button pins, active-high
- btn_level  out  N_BTN  debounced button state
- btn_press  out  N_BTN  one-cycle pulse on accepted 0→1 transition
- btn_release  out  N_BTN  one-cycle pulse on accepted 1→0 transition

Behaviour:
- Clocking and reset:
  - One clock (`clk`). Reset is synchronous and active-low on `nRst`, sampled on the rising edge of `clk`.
  - On reset: sync flops = 0, counters = 0, `btn_level` = 0, `btn_press` = 0, `btn_release` = 0.
  - Reset asserted mid-count discards the count. No pulse is generated by reset itself.
- Synchronisation:
  - Two-flop synchroniser per bit (`sync1` → `sync2`).
  - The synchroniser runs every cycle regardless of `en`.
- Per-channel debounce, evaluated on each rising edge with `nRst` = 1:
  - `sync2` == `btn_level`: `cnt` ← 0.
  - `sync2` != `btn_level`, `en` = 1, `cnt` == DEBOUNCE_CYCLES-1:
    - `btn_level` ← `sync2`, `cnt` ← 0.
    - `btn_press` ← `sync2`, `btn_release` ← !`sync2`.
  - `sync2` != `btn_level`, `en` = 1, otherwise: `cnt` ← `cnt`+1.
  - `sync2` != `btn_level`, `en` = 0: `cnt` holds.
- Pulse outputs:
  - `btn_press` and `btn_release` are registered and default to 0 every cycle not matching the accept condition.
  - Each pulse is high for exactly one cycle, coincident with the `btn_level` change.
  - `btn_press` and `btn_release` are never both high on the same bit.
- Latency with `en` held high:
  - Raw change sampled at edge k.
  - `sync2` shows the new value after edge k+1.
  - `btn_level` and the pulse update after edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection:
  - Any return of `sync2` to `btn_level` before acceptance clears `cnt`.
  - The next mismatch restarts counting from 0. Bounces shorter than DEBOUNCE_CYCLES never reach outputs.
- DEBOUNCE_CYCLES = 1: accepted on the first enabled mismatching edge.
- Channels are fully independent. Simultaneous changes on multiple bits are each handled on their own timing.
- Counter width: `cnt` never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Decomposition:
- Shared package (`breakout_pkg`):
  - Button index constants: BTN_LEFT = 0, BTN_RIGHT = 1, BTN_SELECT = 2.
  - N_BTN = 3.
  - Default DEBOUNCE_CYCLES value.
- One sub-module, `debounce_channel`:
  - Per bit: synchroniser, counter, level and pulse registers.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated N_BTN times in a generate loop by `button_conditioner`.

Test Plan:
- Reset release: all outputs 0 at reset and for the first 10 cycles after release, with `btn_raw` = 0.
- Clean press (DEBOUNCE_CYCLES = 4, `en` = 1):
  - `btn_raw[0]` 0→1 sampled at edge 0.
  - `btn_level[0]` = 1 and `btn_press[0]` = 1 after edge 5.
  - `btn_press[0]` = 0 after edge 6.
  - `btn_release` stays 0.
- Bounce (DEBOUNCE_CYCLES = 4):
  - `btn_raw[1]` toggles 1,0,1,0 at 3-cycle spacing: `btn_level[1]` stays 0 and no pulses.
  - Then held at 1: press pulse exactly 5 cycles after the final sampled rise.
- Enable gating (DEBOUNCE_CYCLES = 4): press `btn_raw[2]` with `en` high 2 cycles, low 10 cycles, then high again.
  - `btn_level[2]` rises after exactly 2 further enabled edges.
  - No pulse while `en` = 0.
- Release and simultaneity (DEBOUNCE_CYCLES = 4):
  - With all levels = 1, drop `btn_raw[0]` and `btn_raw[2]` on the same edge.
  - `btn_release` = 3'b101 for one cycle, 5 cycles later.
  - `btn_level` = 3'b010.
- Reset mid-count: assert `nRst` = 0 for 1 cycle while a count is at 3 of 4.
  - Outputs = 0 and the count restarts.
  - Level accepted DEBOUNCE_CYCLES+2 edges after reset release, not earlier.
